// File: rtl/fp_add_pipe.sv
// Pipelined IEEE-754 add/sub: 3 register stages, 1 op/cycle, all stages stall together on !out_ready.
// FP_ADD_DENORM_EN enables gradual underflow; without it subnormals flush to signed zero.
module fp_add_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] in_a,
  input  logic [EXP_W+MAN_W:0] in_b,
  input  logic                 in_sub,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] out_res,
  output logic [3:0]           out_flags
);
  localparam int W   = 1 + EXP_W + MAN_W;
  localparam int M   = MAN_W + 5;
  localparam int EW  = EXP_W + 2;
  localparam int SHW = $clog2(M) + 1;
  localparam logic signed [EW-1:0] ONE  = EW'(1);
  localparam logic signed [EW-1:0] EMAX = EW'((1 << EXP_W) - 1);
`ifdef FP_ADD_DENORM_EN
  localparam bit DENORM = 1'b1;
`else
  localparam bit DENORM = 1'b0;
`endif

  logic             r_s1_vld, r_s1_nan, r_s1_inv, r_s1_inf, r_s1_inf_sign;
  logic             r_s1_sign, r_s1_zsign, r_s1_sub;
  logic [EXP_W-1:0] r_s1_exp;
  logic [M-1:0]     r_s1_ml, r_s1_ms;
  logic             r_s2_vld, r_s2_nan, r_s2_inv, r_s2_inf, r_s2_inf_sign;
  logic             r_s2_sign, r_s2_zsign;
  logic [EXP_W-1:0] r_s2_exp;
  logic [M-1:0]     r_s2_sum;
  logic             r_out_vld;
  logic [W-1:0]     r_out_res;
  logic [3:0]       r_out_flags;

  logic w_adv;
  assign w_adv     = ~r_out_vld | out_ready;
  assign in_ready  = w_adv & ~rst;
  assign out_valid = r_out_vld;
  assign out_res   = r_out_res;
  assign out_flags = r_out_flags;

  // Stage 1: unpack, classify, order by magnitude, align smaller operand
  logic             w_sa, w_sb;
  logic [EXP_W-1:0] w_ea, w_eb, w_ea_eff, w_eb_eff, w_el, w_es, w_diff;
  logic [MAN_W-1:0] w_fa, w_fb, w_fa_eff, w_fb_eff;
  logic             w_a_dn, w_b_dn, w_a_inf, w_b_inf, w_a_nan, w_b_nan, w_a_big;
  logic [M-1:0]     w_ma, w_mb, w_ml, w_ms, w_ms_al;
  logic [2*M-1:0]   w_wide;

  assign w_sa = in_a[W-1];
  assign w_sb = in_b[W-1] ^ in_sub;
  assign w_ea = in_a[W-2 -: EXP_W];
  assign w_eb = in_b[W-2 -: EXP_W];
  assign w_fa = in_a[MAN_W-1:0];
  assign w_fb = in_b[MAN_W-1:0];

  assign w_a_dn  = ~|w_ea;
  assign w_b_dn  = ~|w_eb;
  assign w_a_inf = (&w_ea) & ~|w_fa;
  assign w_b_inf = (&w_eb) & ~|w_fb;
  assign w_a_nan = (&w_ea) & |w_fa;
  assign w_b_nan = (&w_eb) & |w_fb;

  // Mantissa layout: {carry, hidden, frac, guard, round, sticky}
  assign w_fa_eff = (DENORM || !w_a_dn) ? w_fa : '0;
  assign w_fb_eff = (DENORM || !w_b_dn) ? w_fb : '0;
  assign w_ea_eff = w_a_dn ? EXP_W'(1) : w_ea;
  assign w_eb_eff = w_b_dn ? EXP_W'(1) : w_eb;
  assign w_ma     = {1'b0, ~w_a_dn, w_fa_eff, 3'b000};
  assign w_mb     = {1'b0, ~w_b_dn, w_fb_eff, 3'b000};

  assign w_a_big = {w_ea_eff, w_ma} >= {w_eb_eff, w_mb};
  assign w_el    = w_a_big ? w_ea_eff : w_eb_eff;
  assign w_es    = w_a_big ? w_eb_eff : w_ea_eff;
  assign w_ml    = w_a_big ? w_ma : w_mb;
  assign w_ms    = w_a_big ? w_mb : w_ma;
  assign w_diff  = w_el - w_es;

  // Bits shifted out of the low half collapse into the sticky LSB
  assign w_wide  = {w_ms, {M{1'b0}}} >> w_diff;
  assign w_ms_al = (int'(w_diff) >= MAN_W + 3) ? {{(M-1){1'b0}}, |w_ms}
                 : {w_wide[2*M-1:M+1], w_wide[M] | (|w_wide[M-1:0])};

  // Stage 2: magnitude add/subtract
  logic [M-1:0] w_sum;
  assign w_sum = r_s1_sub ? (r_s1_ml - r_s1_ms) : (r_s1_ml + r_s1_ms);

  // Stage 3: normalise, round to nearest even, pack
  logic [SHW-1:0]         w_lzc, w_sh;
  logic signed [EW-1:0]   w_e, w_en, w_eo;
  logic [EW-1:0]          w_room;
  logic [M-2:0]           w_norm;
  logic [MAN_W+1:0]       w_rsum;
  logic [MAN_W-1:0]       w_fo;
  logic                   w_inc, w_inexact, w_tiny;
  logic [W-1:0]           w_res;
  logic [3:0]             w_flags;

  always_comb begin
    w_lzc = SHW'(M - 1);
    for (int i = 0; i < M - 1; i++)
      if (r_s2_sum[i]) w_lzc = SHW'(M - 2 - i);
  end

  assign w_e    = signed'({2'b00, r_s2_exp});
  assign w_room = {2'b00, r_s2_exp} - EW'(1);
  // Left shift stops at exponent 1; anything still unnormalised is subnormal
  assign w_sh   = (int'(w_lzc) > int'(w_room)) ? SHW'(w_room) : w_lzc;

  always_comb begin
    if (r_s2_sum[M-1]) begin
      w_norm = {r_s2_sum[M-1:2], r_s2_sum[1] | r_s2_sum[0]};
      w_en   = w_e + ONE;
    end else begin
      w_norm = r_s2_sum[M-2:0] << w_sh;
      w_en   = w_e - signed'(EW'(w_sh));
    end
  end

  assign w_inc     = w_norm[2] & (w_norm[3] | w_norm[1] | w_norm[0]);
  assign w_inexact = |w_norm[2:0];
  assign w_tiny    = ~w_norm[M-2];
  assign w_rsum    = {1'b0, w_norm[M-2:3]} + {{(MAN_W+1){1'b0}}, w_inc};

  always_comb begin
    if (w_rsum[MAN_W+1]) begin
      w_eo = w_en + ONE;
      w_fo = '0;
    end else if (w_rsum[MAN_W]) begin
      w_eo = w_en;
      w_fo = w_rsum[MAN_W-1:0];
    end else begin
      w_eo = '0;
      w_fo = w_rsum[MAN_W-1:0];
    end
  end

  always_comb begin
    w_res   = '0;
    w_flags = '0;
    if (r_s2_nan) begin
      w_res   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      w_flags = {r_s2_inv, 3'b000};
    end else if (r_s2_inf) begin
      w_res = {r_s2_inf_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (r_s2_sum == '0) begin
      w_res = {r_s2_zsign, {(W-1){1'b0}}};
    end else if (!DENORM && w_tiny) begin
      w_res   = {r_s2_sign, {(W-1){1'b0}}};
      w_flags = 4'b0011;
    end else if (w_eo >= EMAX) begin
      w_res   = {r_s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      w_flags = 4'b0101;
    end else begin
      w_res   = {r_s2_sign, w_eo[EXP_W-1:0], w_fo};
      w_flags = {2'b00, w_tiny & w_inexact, w_inexact};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_vld    <= 1'b0;
      r_s2_vld    <= 1'b0;
      r_out_vld   <= 1'b0;
      r_out_res   <= '0;
      r_out_flags <= '0;
    end else if (w_adv) begin
      r_s1_vld      <= in_valid & in_ready;
      r_s1_nan      <= w_a_nan | w_b_nan | (w_a_inf & w_b_inf & (w_sa ^ w_sb));
      r_s1_inv      <= w_a_inf & w_b_inf & (w_sa ^ w_sb);
      r_s1_inf      <= w_a_inf | w_b_inf;
      r_s1_inf_sign <= w_a_inf ? w_sa : w_sb;
      r_s1_sign     <= w_a_big ? w_sa : w_sb;
      r_s1_zsign    <= w_sa & w_sb;
      r_s1_sub      <= w_sa ^ w_sb;
      r_s1_exp      <= w_el;
      r_s1_ml       <= w_ml;
      r_s1_ms       <= w_ms_al;

      r_s2_vld      <= r_s1_vld;
      r_s2_nan      <= r_s1_nan;
      r_s2_inv      <= r_s1_inv;
      r_s2_inf      <= r_s1_inf;
      r_s2_inf_sign <= r_s1_inf_sign;
      r_s2_sign     <= r_s1_sign;
      r_s2_zsign    <= r_s1_zsign;
      r_s2_exp      <= r_s1_exp;
      r_s2_sum      <= w_sum;

      r_out_vld <= r_s2_vld;
      if (r_s2_vld) begin
        r_out_res   <= w_res;
        r_out_flags <= w_flags;
      end
    end
  end

endmodule

// File: doc/fp_add_pipe.md
# fp_add_pipe

Parametrised, pipelined IEEE-754 binary floating-point adder/subtractor with valid/ready handshakes on input and output. It is the registered successor of the combinational single-precision adder. The block generalises the format through exponent and mantissa width parameters, adds a subtract mode, round-to-nearest-even, special-value handling and exception flags. It sits between an operand source and a result consumer, one operation per cycle at full throughput.

## Interface
- EXP_W, 8, exponent field width (≥3)
- MAN_W, 23, stored fraction width (≥2); word width W = 1+EXP_W+MAN_W
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- in_valid  input  1  operand pair present
- in_ready  output  1  block accepts operands this cycle
- in_a  input  W  operand A {sign, exp, frac}
- in_b  input  W  operand B
- in_sub  input  1  1: compute A−B (B sign inverted); 0: A+B
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result this cycle
- out_res  output  W  result
- out_flags  output  4  {invalid, overflow, underflow, inexact}

## Operation
- Transfer on a port occurs when valid & ready are both high at a clock edge.
- Stage 1 handles operand preparation. It applies in_sub, classifies operands (zero/normal/subnormal/inf/NaN) and orders them by magnitude (exponent, then fraction). It restores the hidden bit and right-aligns the smaller operand by the exponent difference into MAN_W+4 bits (hidden, frac, guard, round). All shifted-out bits OR into sticky. A difference ≥ MAN_W+3 yields smaller = sticky only.
- Stage 2 performs a magnitude add or subtract, selected by XNOR of the signs. The result sign is the larger operand's sign.
- Stage 3 handles normalisation, rounding and packing.
  - On carry-out: shift right 1, exp+1, fold the dropped bit into sticky.
  - Otherwise: left-shift by the leading-zero count, limited so exp never drops below 1.
  - Round to nearest even: increment when G & (R | S | LSB). A rounding carry renormalises.
  - inexact = G|R|S before rounding.
- Special results:
  - Any NaN in: canonical quiet NaN (sign 0, exp all ones, frac MSB 1, rest 0).
  - inf − inf: canonical NaN with invalid=1.
  - inf ± finite: that inf.
  - Exact cancellation: +0. Exception: (−0)+(−0) gives −0.
  - Overflow (exp ≥ all ones after rounding): signed inf, overflow=1, inexact=1.
- Exponent arithmetic uses EXP_W+2 signed bits to detect overflow and underflow without wrap.

## Timing
- Latency 3 cycles from input transfer to out_valid, with no bubbles when out_ready=1. Throughput is 1 op/cycle.
- Stalling is global: enable = !out_valid | out_ready. All stage registers and valid bits advance only when enable=1.
- in_ready = enable & !rst. in_ready is combinational from out_ready and out_valid.
- With out_ready held low, exactly 3 operations are accepted before in_ready falls (one per stage). out_res and out_flags stay stable while out_valid=1 and out_ready=0.
- Empty pipeline: stage valids are 0 and out_valid=0. Bubbles propagate as valid=0.
- Reset values: out_valid=0, out_res=0, out_flags=0, all stage valid bits 0, in_ready=0 while rst=1.
- Reset mid-operation discards all in-flight operations. out_valid=0 in the cycle after the reset edge, and no stale result is ever presented.
- Input transfer and output transfer in the same cycle are legal and lose nothing.

## Configuration
- FP_ADD_DENORM_EN defined:
  - Subnormal inputs are used with an effective exponent of 1 and hidden bit 0.
  - Results below the minimum normal are delivered as subnormals (exp 0) with gradual rounding.
  - underflow=1 only when the result is tiny and inexact.
- FP_ADD_DENORM_EN undefined (flush-to-zero):
  - Subnormal inputs are treated as signed zero.
  - Any result below the minimum normal becomes signed zero with underflow=1 and inexact=1.

## Test plan
- Default params, 0x3F800000 + 0x3F800000, in_sub=0 -> 0x40000000, flags 0, out_valid exactly 3 cycles after the transfer.
- 0x40400000 with in_sub=1 and 0x3F800000 -> 0x40000000. 0x3F800000 − 0x3F800000 -> 0x00000000 (+0), flags 0.
- Tie rounding: 0x3F800000 + 0x33800000 -> 0x3F800000, inexact. 0x3F800001 + 0x33800000 -> 0x3F800002, inexact.
- 0x7F800000 − 0x7F800000 -> 0x7FC00000, invalid. 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000, overflow|inexact.
- 0x00800000 − 0x00400000 -> 0x00400000 with FP_ADD_DENORM_EN, 0x00800000 without.
- Offer 6 back-to-back operations with out_ready=0 for 5 cycles, then 1; assert rst on a separate run mid-stream. Required: 3 accepted before in_ready drops, all 6 results in order with none lost or duplicated; after reset, out_valid=0 next cycle.
